// File: rtl/mult_wide_iter.sv
// mult_wide_iter: unsigned WA x WB multiplier folded over NCHUNK cycles, one WA x WC
// partial product per cycle accumulated at offset cnt*WC; valid/ready on both sides.
module mult_wide_iter #(
    parameter int WA = 149,
    parameter int WB = 48,
    parameter int WC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WA+WB-1:0] p,
    output logic             busy
);
    localparam int NCHUNK = (WB + WC - 1) / WC;
    localparam int WBP    = NCHUNK * WC;
    localparam int WACC   = WA + WBP;
    localparam int WP     = WA + WC;
    localparam int CW     = $clog2(NCHUNK) + 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [WA-1:0]    a_r;
    logic [WBP-1:0]   b_r;
    logic [WACC-1:0]  acc_r;
    logic [CW-1:0]    cnt_r;
    logic [WA+WB-1:0] p_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [31:0]      shamt_s;
    logic [WC-1:0]    chunk_s;
    logic [WP-1:0]    pp_s;
    logic [WACC-1:0]  acc_next_s;
    logic             last_s;
    logic             in_ready_s;
    logic             accept_s;

    // Current chunk of b times a, shifted to its weight and added to the accumulator
    always_comb begin
        shamt_s    = 32'(cnt_r) * 32'(WC);
        chunk_s    = WC'(b_r >> shamt_s);
        pp_s       = WP'(a_r) * WP'(chunk_s);
        acc_next_s = acc_r + (WACC'(pp_s) << shamt_s);
        last_s     = (cnt_r == LAST);
    end

    // Ready when idle, or when the held product is being taken this cycle
    always_comb begin
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_DONE: in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
        accept_s = in_valid & in_ready_s;
    end

    // Operand capture, chunk iteration, product hold and handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= {WA{1'b0}};
            b_r         <= {WBP{1'b0}};
            acc_r       <= {WACC{1'b0}};
            cnt_r       <= {CW{1'b0}};
            p_r         <= {(WA+WB){1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (accept_s) begin
            // also covers the DONE handoff edge: old product leaves, new op starts
            a_r         <= a;
            b_r         <= WBP'(b);
            acc_r       <= {WACC{1'b0}};
            cnt_r       <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CW'(1'b1);
                    if (last_s) begin
                        p_r         <= acc_next_s[WA+WB-1:0];
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign p         = p_r;
    assign busy      = busy_r;

endmodule
